ps2_key_decoder: RTL
====================

# ps2_key_decoder

Receives PS/2 keyboard frames on the board's PS/2 pins and keeps a held/released state for the four driving keys. Its output `key[3:0]` goes directly into `car_ctl.key`, in place of the debounced buttons, with the same bit order. The block runs in the `clk65M` pixel domain. It oversamples the PS/2 clock, so no second clock is needed.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 6500: idle cycles allowed mid-frame before the frame is abandoned (100 µs at 65 MHz).

Ports:
- `pclk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous; the top level drives the inout as input-only.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `key` out 4: held-key state {R, L, D, U}; bit 3 = right, bit 0 = up.
- `scan_code` out 8: last correctly received byte.
- `scan_valid` out 1: one-cycle pulse when `scan_code` updates.
- `frame_err` out 1: one-cycle pulse on a start, parity, stop or timeout error.

## Operation
- **Input sync:** two flops on each of `ps2_clk` and `ps2_data`, plus a third flop on the clock for edge detection. A falling edge is synced-previous = 1 and synced-current = 0. Data is sampled from the synced data line in the edge cycle.
- **Frame FSM:**
  - IDLE: on a falling edge, if data = 0 go to DATA; if data = 1, pulse `frame_err` and stay in IDLE.
  - DATA: shift in 8 bits, LSB first; a 3-bit counter advances on each edge. After bit 7, go to PARITY.
  - PARITY: latch the bit, then go to STOP.
  - STOP: the frame is good only if the stop bit = 1 and the 8 data bits plus parity have odd parity. Good: update `scan_code`, pulse `scan_valid`, run the decoder. Bad: pulse `frame_err`. Either way, return to IDLE.
- **Timeout:** a counter clears on every falling edge and counts while the FSM is outside IDLE. On reaching `TIMEOUT_CYCLES - 1`: return to IDLE, pulse `frame_err`, clear the shift register and the counter.
- **Decoder (good frames only):**
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other code: look up the mapping; on a match set the key bit to `~brk`. Then clear `ext` and `brk`.
  - Mapping, extended only: 0x74 = R, 0x6B = L, 0x72 = D, 0x75 = U. A non-extended 0x74 etc. (keypad) does not match.
  - Unmapped codes and 0xE1 change no key bits but do clear the flags.
- **Errors:** any `frame_err` clears `ext` and `brk`; `key` holds its value.
- **Reset:** `key` = 0, `scan_code` = 0x00, `scan_valid` = 0, `frame_err` = 0, FSM = IDLE, flags = 0, counters = 0. A reset mid-frame discards the partial frame, with no error pulse.

## Timing
- Latency: the stop-bit falling edge on the pin is followed by `scan_valid`, `scan_code` and `key` updating together, 4 `pclk` cycles later (2 sync, 1 edge, 1 register).
- `scan_valid` and `frame_err` never assert in the same cycle. Each is exactly one cycle wide.
- The decoder sees one byte per frame. Bytes are at least about 60 µs apart, so no back-pressure is needed.
- When a timeout and a falling edge coincide, the edge wins: the counter clears and the frame continues.
- A glitch shorter than 2 `pclk` cycles may register. No deglitching beyond the synchronizer is required.

## Configuration
- `PS2_WASD_EN` defined: the non-extended codes 0x1D = U (W), 0x1C = L (A), 0x1B = D (S), 0x23 = R (D) also drive the key bits, with the same make/break handling. An arrow key and its letter key share one bit; the last event wins.
- `PS2_WASD_EN` undefined: those codes are unmapped and only clear the flags.

## Test plan
- Frames E0, 74 (well-formed, 12.5 kHz PS/2 clock): `scan_valid` pulses twice, `key` = 4'b1000 four cycles after the second stop edge. Then E0, F0, 74: `key` = 4'b0000.
- E0 75 then E0 6B, no breaks: `key` = 4'b0101. Then E0 F0 75: `key` = 4'b0100.
- Byte 0x1C sent with wrong parity: `frame_err` pulses once, `scan_valid` stays 0, `scan_code` is unchanged. A following good 0x1C gives `scan_code` = 0x1C, with `key` unchanged when the macro is undefined and `key[2]` = 1 when it is defined.
- Clock stopped after 5 data bits for 7000 cycles: `frame_err` pulses exactly at idle cycle 6500 and the FSM is in IDLE. A following full E0 frame is accepted.
- E0 sent, then 0x74 with a bad stop bit, then a good 0x74: no key change (the error cleared `ext`, and a non-extended 0x74 is unmapped).
- `rst` asserted for one cycle mid-frame while `key` = 4'b1111: the next cycle shows `key` = 0, `scan_code` = 0, no pulses. The remaining bits of the interrupted frame are rejected (the first stray edge with data = 1 gives `frame_err`) or ignored until a real start bit.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: oversamples the PS/2 pins, frames bytes and tracks held arrow keys {R, L, D, U}.
// Define PS2_WASD_EN to also map the W/A/S/D letter keys onto the same key bits.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Sync flops reset high (idle bus level) so reset never fakes a falling edge.
  logic          clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic          fall_q, data_q;
  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [CW-1:0] to_cnt;
  logic          ext_flag, brk_flag;
  logic          do_shift, do_parity, good_nxt, err_nxt, timeout_hit;
  logic          map_hit;
  logic [1:0]    map_idx;

  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fall_q <= 1'b0;
      data_q <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      fall_q <= clk_s3 & ~clk_s2;
      data_q <= dat_s2;
    end
  end

  always_comb begin
    state_nxt   = state;
    do_shift    = 1'b0;
    do_parity   = 1'b0;
    good_nxt    = 1'b0;
    err_nxt     = 1'b0;
    timeout_hit = (state != S_IDLE) && !fall_q && (to_cnt == TO_LAST);
    if (fall_q) begin
      case (state)
        S_IDLE: begin
          if (!data_q) state_nxt = S_DATA;
          else         err_nxt   = 1'b1;
        end
        S_DATA: begin
          do_shift = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          do_parity = 1'b1;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (data_q && (^{shift_reg, parity_bit})) good_nxt = 1'b1;
          else                                      err_nxt  = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
  end

  // Key lookup for the completed byte; letter keys only exist in the WASD build.
  always_comb begin
    map_hit = 1'b0;
    map_idx = 2'd0;
    if (ext_flag) begin
      case (shift_reg)
        8'h74:   begin map_hit = 1'b1; map_idx = 2'd3; end
        8'h6B:   begin map_hit = 1'b1; map_idx = 2'd2; end
        8'h72:   begin map_hit = 1'b1; map_idx = 2'd1; end
        8'h75:   begin map_hit = 1'b1; map_idx = 2'd0; end
        default: map_hit = 1'b0;
      endcase
    end
`ifdef PS2_WASD_EN
    else begin
      case (shift_reg)
        8'h23:   begin map_hit = 1'b1; map_idx = 2'd3; end
        8'h1C:   begin map_hit = 1'b1; map_idx = 2'd2; end
        8'h1B:   begin map_hit = 1'b1; map_idx = 2'd1; end
        8'h1D:   begin map_hit = 1'b1; map_idx = 2'd0; end
        default: map_hit = 1'b0;
      endcase
    end
`endif
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      key        <= 4'b0000;
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      scan_valid <= good_nxt;
      frame_err  <= err_nxt;
      if (fall_q) begin
        to_cnt <= '0;
      end else if (timeout_hit) begin
        to_cnt    <= '0;
        shift_reg <= 8'h00;
        bit_cnt   <= 3'd0;
      end else if (state != S_IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (fall_q && state == S_IDLE) bit_cnt <= 3'd0;
      if (do_shift) begin
        shift_reg <= {data_q, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (do_parity) parity_bit <= data_q;
      if (err_nxt) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
      if (good_nxt) begin
        scan_code <= shift_reg;
        if (shift_reg == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          if (map_hit) key[map_idx] <= ~brk_flag;
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  assign state_dbg = state;

endmodule
